clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Downstream consumer of the divide-by-4 clock output. It samples the divided clock in the source `clk` domain and produces single-cycle rise/fall ticks for enable-based logic. It also measures the divided-clock period in source cycles and reports lock or fault against the expected ratio. Downstream logic uses it as the clock-enable source and as a health check on the divider.

## Interface
- `DIV`, 4: expected divide ratio, in source cycles per divided period; must be ≥ 2.
- `SYNC_STAGES`, 2: synchronizer depth on `clk_div_in`; must be ≥ 2.
- `LOCK_CNT`, 4: number of consecutive matching periods required to assert `locked`.
- `CNT_W`, 8: width of the period counter and of `period`.
- `TIMEOUT`, 4*DIV: number of source cycles without a rising edge before a fault is raised; must be < 2^CNT_W.
- `clk`  in  1  source clock; all logic is on its rising edge.
- `rst`  in  1  reset.
  - One clock; reset is asynchronous and active-low.
  - `rst` = 0 clears all state immediately; deassertion is synchronous in effect.
- `clk_div_in`  in  1  divided clock under observation; treated as asynchronous.
- `tick_rise`  out  1  one-cycle pulse per detected rising edge.
- `tick_fall`  out  1  one-cycle pulse per detected falling edge.
- `period`  out  CNT_W  last measured rise-to-rise period, in source cycles.
- `period_valid`  out  1  one-cycle pulse when `period` updates.
- `locked`  out  1  high while in LOCK.
- `fault`  out  1  high while in FAULT.

## Operation
- Synchronizer: a `SYNC_STAGES`-flop chain on `clk_div_in`, followed by one history flop `prev`.
- Edge detection:
  - `rise_det` = `sync & ~prev`.
  - `fall_det` = `~sync & prev`.
  - `tick_rise` and `tick_fall` are registered copies of these.
- Period counter `cnt`:
  - On `rise_det`: `cnt` <= 1.
  - Otherwise: `cnt` <= `cnt` + 1, saturating at 2^CNT_W − 1. It never wraps.
- Measurement:
  - On `rise_det` with `seen` = 1: `period` <= `cnt` and `period_valid` pulses.
  - On the first `rise_det` after reset, `seen` is set instead and no measurement is made.
- Match test: `period` value equals `DIV`. A counter `match` (width clog2(LOCK_CNT+1)) tracks consecutive matches.
- State machine, states IDLE, ACQ, LOCK, FAULT:
  - IDLE: on first `rise_det` -> ACQ with `match` = 0.
  - ACQ, measured period matches:
    - Increment `match`.
    - If `match` reaches `LOCK_CNT` -> LOCK.
  - ACQ, measured period mismatches: `match` <= 0 and stay in ACQ. No fault is raised.
  - LOCK, measured period mismatches -> FAULT and clear `match`.
  - FAULT, measured period matches -> ACQ with `match` = 1.
  - Any state: `cnt` ≥ `TIMEOUT` with no `rise_det` in that cycle -> FAULT. This also covers a stopped clock out of IDLE.
  - In FAULT with the timeout still active: stay in FAULT.
- Simultaneous timeout and `rise_det` in the same cycle: the edge wins. The cycle is evaluated as a measurement, not a timeout.
- `period` holds its value between updates, including across FAULT.

## Timing
- Reset values: `tick_rise`, `tick_fall`, `period_valid`, `locked`, `fault` = 0; `period` = 0; `cnt` = 0; `seen` = 0; state = IDLE; synchronizer and `prev` = 0.
- Edge latency: a `clk_div_in` transition sampled at edge k gives `tick_rise`/`tick_fall` high in cycle k + SYNC_STAGES + 1, for exactly one cycle.
- `period_valid` is coincident with `tick_rise`, i.e. registered in the same cycle as the tick.
- `locked` and `fault` rise one cycle after the deciding `period_valid` or timeout cycle.
- Steady DIV = 4, 50 % duty: a `tick_rise` every 4 cycles, with `tick_fall` 2 cycles after each `tick_rise`.
- Reset mid-operation: outputs drop to reset values asynchronously. After release, the first `rise_det` produces no `period_valid`.

## Test plan
- Reset release, divide-by-4 running: first `tick_rise` gives no `period_valid`. Next 4 `period_valid` pulses carry `period` = 4. `locked` = 1 one cycle after the 4th pulse; `fault` stays 0.
- Locked, then `clk_div_in` held low: `fault` = 1 once `cnt` reaches 16. `locked` = 0 and `period` keeps 4.
- Locked, then a divide-by-8 waveform: first `period_valid` carries 8 -> FAULT. Periods continue at 8, state stays FAULT, and `match` never increments.
- FAULT, then divide-by-4 restored:
  - First period = 4 -> ACQ with `match` = 1.
  - `locked` = 1 after 3 further matching periods.
- Alternating periods 4, 6, 4, 6 from reset: state stays ACQ, `locked` = 0, `fault` = 0, and `period` toggles between 4 and 6.
- Assert `rst` = 0 while LOCK, for 3 cycles mid-period: all outputs 0 immediately. After release, the first `tick_rise` has no `period_valid`, and relock takes 4 more periods.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Samples a divided clock in the source domain, emits rise/fall ticks,
// measures rise-to-rise period and tracks lock/fault against DIV.
module clk_div_monitor #(
    parameter int DIV         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 4 * DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] DIV_V = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CMAX  = '1;
    localparam logic [MW-1:0]    LCK_V = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCK,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   seen_q;
    logic [MW-1:0]          match_q, match_d;

    logic sync_v;
    logic rise_det;
    logic fall_det;
    logic meas;
    logic hit;
    logic timeout;

    assign sync_v   = sync_q[SYNC_STAGES-1];
    assign rise_det = sync_v & ~prev_q;
    assign fall_det = ~sync_v & prev_q;
    assign meas     = rise_det & seen_q;
    assign hit      = (cnt_q == DIV_V);
    // An edge in the same cycle as the timeout is treated as a measurement.
    assign timeout  = (cnt_q >= TO_V) & ~rise_det;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_div_in};
            prev_q <= sync_v;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            if (rise_det) begin
                cnt_q  <= CNT_W'(1);
                seen_q <= 1'b1;
            end else if (cnt_q != CMAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (timeout) begin
            state_d = S_FAULT;
            match_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise_det) begin
                        state_d = S_ACQ;
                        match_d = '0;
                    end
                end
                S_ACQ: begin
                    if (meas) begin
                        if (hit) begin
                            match_d = match_q + MW'(1);
                            if (match_d == LCK_V) begin
                                state_d = S_LOCK;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                S_LOCK: begin
                    if (meas && !hit) begin
                        state_d = S_FAULT;
                        match_d = '0;
                    end
                end
                S_FAULT: begin
                    if (meas && hit) begin
                        state_d = S_ACQ;
                        match_d = MW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_rise    <= 1'b0;
            tick_fall    <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
            locked       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            tick_rise    <= rise_det;
            tick_fall    <= fall_det;
            period_valid <= meas;
            if (meas) begin
                period <= cnt_q;
            end
            locked <= (state_q == S_LOCK);
            fault  <= (state_q == S_FAULT);
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock, timeout, wrong ratio,
// recovery, reset mid-lock and alternating periods.
module tb_clk_div_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_div_in = 1'b0;
    logic       tick_rise;
    logic       tick_fall;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       fault;

    always #5 clk = ~clk;

    clk_div_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .clk_div_in   (clk_div_in),
        .tick_rise    (tick_rise),
        .tick_fall    (tick_fall),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int n_rise = 0;
    int n_pv = 0;
    int pv_bad = 0;
    int last_rise_cyc = 0;
    int rise_gap = 0;
    int fall_gap = 0;
    int lock_cyc = -1;
    logic locked_d = 1'b0;
    int pq[$];
    int pcq[$];

    int s_rise;
    int s_pv;
    int s_q;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pget(input int i);
        if (i < pq.size()) return pq[i];
        return -1;
    endfunction

    function automatic int cget(input int i);
        if (i < pcq.size()) return pcq[i];
        return -1000;
    endfunction

    // Output monitor, sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                if (tick_rise) begin
                    n_rise++;
                    rise_gap = cyc - last_rise_cyc;
                    last_rise_cyc = cyc;
                end
                if (tick_fall) begin
                    fall_gap = cyc - last_rise_cyc;
                end
                if (period_valid) begin
                    n_pv++;
                    pq.push_back(int'(period));
                    pcq.push_back(cyc);
                    if (!tick_rise) pv_bad++;
                end
                if (locked && !locked_d) lock_cyc = cyc;
            end
            locked_d = locked;
        end
    end

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) begin
                @(negedge clk);
                clk_div_in = 1'b1;
            end
            for (int i = 0; i < lo; i++) begin
                @(negedge clk);
                clk_div_in = 1'b0;
            end
        end
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_div_in = 1'b0;
        end
    endtask

    task automatic snap();
        s_rise = n_rise;
        s_pv   = n_pv;
        s_q    = pq.size();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clk_div_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tick_rise", int'(tick_rise), 0);
        chk("rst_tick_fall", int'(tick_fall), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        @(negedge clk);
        rst = 1'b1;

        // divide-by-4 from reset: first rise unmeasured, lock after 4 matches
        snap();
        wave(2, 2, 4);
        chk("t1_rises", n_rise - s_rise, 4);
        chk("t1_pvs", n_pv - s_pv, 3);
        chk("t1_p0", pget(s_q), 4);
        chk("t1_p2", pget(s_q + 2), 4);
        chk("t1_locked_early", int'(locked), 0);
        wave(2, 2, 2);
        chk("t1_locked", int'(locked), 1);
        chk("t1_fault", int'(fault), 0);
        chk("t1_lock_lat", lock_cyc - cget(s_q + 3), 1);
        chk("t1_rise_gap", rise_gap, 4);
        chk("t1_fall_gap", fall_gap, 2);
        chk("t1_pv_with_tick", pv_bad, 0);

        // stopped clock -> timeout fault, period held
        hold_low(10);
        chk("t2_fault_early", int'(fault), 0);
        hold_low(14);
        chk("t2_fault", int'(fault), 1);
        chk("t2_locked", int'(locked), 0);
        chk("t2_period", int'(period), 4);

        // restart divide-by-4 out of timeout fault
        snap();
        wave(2, 2, 4);
        chk("t3_long_period", pget(s_q), 28);
        chk("t3_p1", pget(s_q + 1), 4);
        chk("t3_fault", int'(fault), 0);
        chk("t3_locked_early", int'(locked), 0);
        wave(2, 2, 2);
        chk("t3_locked", int'(locked), 1);

        // divide-by-8 while locked
        snap();
        wave(4, 4, 4);
        chk("t4_p0", pget(s_q), 4);
        chk("t4_p1", pget(s_q + 1), 8);
        chk("t4_p3", pget(s_q + 3), 8);
        chk("t4_fault", int'(fault), 1);
        chk("t4_locked", int'(locked), 0);
        chk("t4_period", int'(period), 8);

        // divide-by-4 restored: ACQ at first match, lock after 3 more
        snap();
        wave(2, 2, 4);
        chk("t5_p0", pget(s_q), 8);
        chk("t5_p1", pget(s_q + 1), 4);
        chk("t5_fault", int'(fault), 0);
        chk("t5_locked_early", int'(locked), 0);
        wave(2, 2, 2);
        chk("t5_locked", int'(locked), 1);

        // asynchronous reset mid-period while locked
        @(negedge clk);
        clk_div_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clk_div_in = 1'b0;
        #1;
        chk("t6_locked", int'(locked), 0);
        chk("t6_period", int'(period), 0);
        chk("t6_pv", int'(period_valid), 0);
        chk("t6_fault", int'(fault), 0);
        chk("t6_tick_rise", int'(tick_rise), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        snap();
        wave(2, 2, 4);
        chk("t6_rises", n_rise - s_rise, 4);
        chk("t6_pvs", n_pv - s_pv, 3);
        chk("t6_locked_early", int'(locked), 0);
        wave(2, 2, 2);
        chk("t6_relock", int'(locked), 1);

        // alternating 4/6 periods never lock or fault
        do_reset();
        snap();
        wave(2, 2, 1);
        for (int k = 0; k < 3; k++) begin
            wave(3, 3, 1);
            wave(2, 2, 1);
        end
        chk("t7_pvs", n_pv - s_pv, 6);
        chk("t7_p0", pget(s_q), 4);
        chk("t7_p1", pget(s_q + 1), 6);
        chk("t7_p4", pget(s_q + 4), 4);
        chk("t7_p5", pget(s_q + 5), 6);
        chk("t7_period", int'(period), 6);
        chk("t7_locked", int'(locked), 0);
        chk("t7_fault", int'(fault), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
